// File: rtl/fm_pkg.sv
// Shared definitions for the FM demodulator scheduler.
//   state_t    : FSM state encoding as it appears on the 'state' port
//   MIDSCALE   : DAC code for silence; unsigned samples have their zero at 128
//   *_DEF      : default parameter values for fm_demod_sched
package fm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_MUTE   = 2'd3
  } state_t;

  localparam logic [7:0] MIDSCALE = 8'd128;

  localparam int DIV_DEF     = 5;
  localparam int WARM_N_DEF  = 64;
  localparam int OTR_LIM_DEF = 4;
  localparam int REC_N_DEF   = 256;

endpackage

// File: rtl/fm_samp_strobe.sv
// Sample-strobe generator: divides sys_clk by DIV while enabled.
//   sys_clk : clock
//   sys_rst : synchronous active-high reset
//   en      : count only while high; the count is held at 0 otherwise
//   clr     : synchronous clear of the count
//   samp_en : one-cycle strobe in the last cycle of each DIV-cycle period
module fm_samp_strobe #(
  parameter int DIV = 5
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic samp_en
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: reset is sampled on the clock edge only (no rst in the sensitivity
  // list), so it behaves like any other synchronous input to the flops.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Held at 0 while disabled, so the first strobe after enable lands DIV
  // cycles later.
  assign samp_en = en && (cnt == LAST);

endmodule

// File: rtl/fm_demod_sched.sv
// FM demodulator scheduler: sequences ADC sampling, demodulator flush,
// DAC output and over-range muting.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   start, stop      : one-cycle acquisition requests (stop has priority)
//   ad_otr           : ADC over-range flag, looked at only on samp_en
//   demod_data/valid : demodulator output sample and qualifier
//   samp_en          : sample strobe to ADC and demodulator
//   demod_flush      : held high for the whole warm-up
//   da_data, da_wr   : DAC sample and write strobe
//   state            : current FSM state (fm_pkg::state_t encoding)
//   ovr_flag         : sticky over-range indicator, cleared by a new start
module fm_demod_sched
  import fm_pkg::*;
#(
  parameter int DIV     = DIV_DEF,
  parameter int WARM_N  = WARM_N_DEF,
  parameter int OTR_LIM = OTR_LIM_DEF,
  parameter int REC_N   = REC_N_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       ad_otr,
  input  logic [7:0] demod_data,
  input  logic       demod_valid,
  output logic       samp_en,
  output logic       demod_flush,
  output logic [7:0] da_data,
  output logic       da_wr,
  output logic [1:0] state,
  output logic       ovr_flag
);

  localparam int WW = $clog2(WARM_N + 1);
  localparam int OW = $clog2(OTR_LIM + 1);
  localparam int RW = $clog2(REC_N + 1);

  state_t        cur_state, nxt_state;
  logic [WW-1:0] warm_cnt;
  logic [OW-1:0] otr_cnt;
  logic [RW-1:0] cln_cnt;
  logic          state_chg;

  fm_samp_strobe #(.DIV(DIV)) u_strobe (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (cur_state != ST_IDLE),
    .clr     (stop),
    .samp_en (samp_en)
  );

  // Each transition fires on the strobe that completes its count, so the
  // counters compare against limit-1 rather than waiting a cycle.
  always_comb begin
    // NOTE: assigning the default before the case guarantees every path
    // drives nxt_state, so no latch is inferred.
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:   if (start) nxt_state = ST_WARMUP;
      ST_WARMUP: if (samp_en && warm_cnt == WW'(WARM_N - 1)) nxt_state = ST_RUN;
      ST_RUN:    if (samp_en && ad_otr && otr_cnt == OW'(OTR_LIM - 1)) nxt_state = ST_MUTE;
      ST_MUTE:   if (samp_en && !ad_otr && cln_cnt == RW'(REC_N - 1)) nxt_state = ST_RUN;
      default:   nxt_state = ST_IDLE;
    endcase
    if (stop) nxt_state = ST_IDLE;
  end

  assign state_chg = (nxt_state != cur_state);

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur_state <= ST_IDLE;
      warm_cnt  <= '0;
      otr_cnt   <= '0;
      cln_cnt   <= '0;
      ovr_flag  <= 1'b0;
      da_data   <= MIDSCALE;
      da_wr     <= 1'b0;
    end else begin
      cur_state <= nxt_state;

      if (state_chg) begin
        warm_cnt <= '0;
        otr_cnt  <= '0;
        cln_cnt  <= '0;
      end else if (samp_en) begin
        case (cur_state)
          ST_WARMUP: warm_cnt <= warm_cnt + 1'b1;
          ST_RUN: begin
            if (!ad_otr)                          otr_cnt <= '0;
            else if (otr_cnt != OW'(OTR_LIM))     otr_cnt <= otr_cnt + 1'b1;
          end
          ST_MUTE: begin
            if (ad_otr)                           cln_cnt <= '0;
            else if (cln_cnt != RW'(REC_N))       cln_cnt <= cln_cnt + 1'b1;
          end
          default: ;
        endcase
      end

      if (cur_state == ST_RUN && nxt_state == ST_MUTE) begin
        ovr_flag <= 1'b1;
      end else if (cur_state == ST_IDLE && nxt_state == ST_WARMUP) begin
        ovr_flag <= 1'b0;
      end

      // The DAC register follows the state being entered, so a stop or a
      // mute silences the output on the very next cycle.
      case (nxt_state)
        ST_RUN: begin
          da_wr <= demod_valid;
          if (demod_valid) da_data <= demod_data;
        end
        ST_MUTE: begin
          da_wr   <= demod_valid;
          da_data <= MIDSCALE;
        end
        default: begin
          da_wr   <= 1'b0;
          da_data <= MIDSCALE;
        end
      endcase
    end
  end

  assign demod_flush = (cur_state == ST_WARMUP);
  assign state       = cur_state;

endmodule

// File: tb/tb_fm_demod_sched.sv
module tb_fm_demod_sched;

  localparam int DIV     = 5;
  localparam int WARM_N  = 64;
  localparam int OTR_LIM = 4;
  localparam int REC_N   = 256;

  logic       sys_clk = 1'b0;
  logic       sys_rst, start, stop, ad_otr, demod_valid;
  logic [7:0] demod_data;
  logic       samp_en, demod_flush, da_wr, ovr_flag;
  logic [7:0] da_data;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  fm_demod_sched #(.DIV(DIV), .WARM_N(WARM_N), .OTR_LIM(OTR_LIM), .REC_N(REC_N)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .stop        (stop),
    .ad_otr      (ad_otr),
    .demod_data  (demod_data),
    .demod_valid (demod_valid),
    .samp_en     (samp_en),
    .demod_flush (demod_flush),
    .da_data     (da_data),
    .da_wr       (da_wr),
    .state       (state),
    .ovr_flag    (ovr_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Waits (bounded) for a strobe, applies the over-range value on it.
  task automatic strobe(input logic otr);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (samp_en === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_timeout: no samp_en within %0d cycles, required one", 4 * DIV);
    end
    ad_otr = otr;
    tick();
    ad_otr = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; ad_otr = 1'b0;
    demod_valid = 1'b0; demod_data = 8'h00;
    tick(); tick();
    n_cmp++;
    if ({state, samp_en, demod_flush, da_wr, da_data, ovr_flag} !== {2'd0, 3'b000, 8'd128, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got st=%0d se=%b fl=%b wr=%b da=%h ovr=%b, required 0 0 0 0 80 0",
               state, samp_en, demod_flush, da_wr, da_data, ovr_flag);
    end
    sys_rst = 1'b0;
    begin
      int hits = 0;
      for (int i = 0; i < 3 * DIV; i++) begin
        tick();
        if (samp_en !== 1'b0 || state !== 2'd0) hits++;
      end
      n_cmp++;
      if (hits !== 0) begin
        n_bad++;
        $display("FAIL idle_quiet: %0d cycles with strobe or non-IDLE, required 0", hits);
      end
    end
  endtask

  // Start from IDLE and follow warm-up into RUN, checking its timing.
  task automatic test_warmup;
    int first = -1, flush_n = 0, strobes = 0, da_bad = 0, k;
    start = 1'b1; tick(); start = 1'b0;
    for (k = 1; k <= 1000; k++) begin
      if (state !== 2'd1) break;
      if (demod_flush === 1'b1) flush_n++;
      if (samp_en === 1'b1) begin strobes++; if (first < 0) first = k; end
      if (da_wr !== 1'b0 || da_data !== 8'd128) da_bad++;
      demod_valid = 1'($urandom % 2);
      demod_data  = 8'($urandom);
      tick();
    end
    demod_valid = 1'b0;
    n_cmp++;
    if (first !== DIV) begin
      n_bad++; $display("FAIL first_strobe: at cycle %0d after start, required %0d", first, DIV);
    end
    n_cmp++;
    if (flush_n !== WARM_N * DIV || k - 1 !== WARM_N * DIV) begin
      n_bad++;
      $display("FAIL warmup_len: flush=%0d warmup=%0d cycles, required %0d", flush_n, k - 1, WARM_N * DIV);
    end
    n_cmp++;
    if (strobes !== WARM_N) begin
      n_bad++; $display("FAIL warmup_strobes: got %0d, required %0d", strobes, WARM_N);
    end
    n_cmp++;
    if (da_bad !== 0) begin
      n_bad++; $display("FAIL warmup_da: %0d cycles with DAC active, required 0", da_bad);
    end
    n_cmp++;
    if (state !== 2'd2 || demod_flush !== 1'b0) begin
      n_bad++; $display("FAIL warmup_exit: st=%0d fl=%b, required 2 0", state, demod_flush);
    end
  endtask

  task automatic test_run_data;
    demod_data = 8'hA5; demod_valid = 1'b1; tick();
    demod_valid = 1'b0; demod_data = 8'h5A;
    n_cmp++;
    if ({da_wr, da_data} !== {1'b1, 8'hA5}) begin
      n_bad++; $display("FAIL run_latency: wr=%b da=%h, required 1 a5", da_wr, da_data);
    end
    tick();
    n_cmp++;
    if ({da_wr, da_data} !== {1'b0, 8'hA5}) begin
      n_bad++; $display("FAIL run_hold: wr=%b da=%h, required 0 a5", da_wr, da_data);
    end
  endtask

  task automatic test_overrange;
    for (int i = 0; i < 3; i++) strobe(1'b1);
    strobe(1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++; $display("FAIL otr_early: st=%0d after 3 consecutive, required 2", state);
    end
    strobe(1'b1);
    n_cmp++;
    if ({state, ovr_flag, da_data} !== {2'd3, 1'b1, 8'd128}) begin
      n_bad++; $display("FAIL otr_mute: st=%0d ovr=%b da=%h, required 3 1 80", state, ovr_flag, da_data);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if ({state, ovr_flag} !== {2'd3, 1'b1}) begin
      n_bad++; $display("FAIL start_ignored: st=%0d ovr=%b, required 3 1", state, ovr_flag);
    end
    demod_data = 8'h3C; demod_valid = 1'b1; tick(); demod_valid = 1'b0;
    n_cmp++;
    if ({da_wr, da_data} !== {1'b1, 8'd128}) begin
      n_bad++; $display("FAIL mute_da: wr=%b da=%h, required 1 80", da_wr, da_data);
    end
  endtask

  task automatic test_recovery;
    for (int i = 0; i < REC_N - 1; i++) strobe(1'b0);
    strobe(1'b1);
    for (int i = 0; i < REC_N - 1; i++) strobe(1'b0);
    n_cmp++;
    if (state !== 2'd3) begin
      n_bad++; $display("FAIL rec_early: st=%0d before final clean strobe, required 3", state);
    end
    strobe(1'b0);
    n_cmp++;
    if ({state, ovr_flag} !== {2'd2, 1'b1}) begin
      n_bad++; $display("FAIL rec_run: st=%0d ovr=%b, required 2 1", state, ovr_flag);
    end
  endtask

  task automatic test_stop;
    int hits = 0;
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++;
    if ({state, samp_en, da_wr, da_data} !== {2'd0, 1'b0, 1'b0, 8'd128}) begin
      n_bad++; $display("FAIL stop_run: st=%0d se=%b wr=%b da=%h, required 0 0 0 80", state, samp_en, da_wr, da_data);
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_cmp++;
    if ({state, ovr_flag} !== {2'd0, 1'b1}) begin
      n_bad++; $display("FAIL start_stop_same: st=%0d ovr=%b, required 0 1", state, ovr_flag);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if ({state, ovr_flag, demod_flush} !== {2'd1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL restart: st=%0d ovr=%b fl=%b, required 1 0 1", state, ovr_flag, demod_flush);
    end
    for (int i = 0; i < DIV + 2; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++;
    if ({state, samp_en, demod_flush} !== {2'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL stop_warmup: st=%0d se=%b fl=%b, required 0 0 0", state, samp_en, demod_flush);
    end
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      if (samp_en !== 1'b0) hits++;
    end
    n_cmp++;
    if (hits !== 0) begin
      n_bad++; $display("FAIL stop_divider: %0d strobes in IDLE, required 0", hits);
    end
  endtask

  task automatic test_reset_mid;
    test_warmup();
    for (int i = 0; i < OTR_LIM; i++) strobe(1'b1);
    demod_valid = 1'b1; demod_data = 8'h77; ad_otr = 1'b1;
    sys_rst = 1'b1; start = 1'b1; stop = 1'b1;
    tick();
    n_cmp++;
    if ({state, samp_en, demod_flush, da_wr, da_data, ovr_flag} !== {2'd0, 3'b000, 8'd128, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got st=%0d se=%b fl=%b wr=%b da=%h ovr=%b, required 0 0 0 0 80 0",
               state, samp_en, demod_flush, da_wr, da_data, ovr_flag);
    end
    sys_rst = 1'b0; start = 1'b0; stop = 1'b0; demod_valid = 1'b0; ad_otr = 1'b0;
    tick();
    test_warmup();
  endtask

  // Random traffic against a model built from strobe-counting rules.
  task automatic test_random;
    int m_state = 0, m_phase = 0, warm_seen = 0, otr_run = 0, clean_run = 0;
    int ns, reported = 0;
    logic m_ovr = 1'b0, exp_wr = 1'b0, exp_se, exp_fl, strb, noisy;
    logic [7:0] exp_da = 8'd128;
    stop = 1'b1; tick(); stop = 1'b0;
    for (int cyc = 0; cyc < 4200; cyc++) begin
      noisy = (cyc >= 400 && cyc < 800) || (cyc >= 2400 && cyc < 2700);
      start       = (cyc == 0);
      demod_valid = 1'($urandom % 2);
      demod_data  = 8'($urandom);
      ad_otr      = noisy ? 1'($urandom % 2) : ($urandom % 600 == 0);

      strb = (m_state != 0) && (m_phase == DIV - 1);
      ns = m_state;
      if (strb) begin
        if (m_state == 1) warm_seen++;
        if (ad_otr) begin otr_run++; clean_run = 0; end
        else        begin clean_run++; otr_run = 0; end
      end
      if (m_state == 0 && start) begin ns = 1; m_ovr = 1'b0; end
      else if (m_state == 1 && warm_seen == WARM_N) ns = 2;
      else if (m_state == 2 && otr_run >= OTR_LIM) begin ns = 3; m_ovr = 1'b1; end
      else if (m_state == 3 && clean_run >= REC_N) ns = 2;
      if (ns != m_state) begin warm_seen = 0; otr_run = 0; clean_run = 0; end
      m_phase = (m_state == 0) ? 0 : (m_phase + 1) % DIV;
      if (ns == 2)      begin exp_wr = demod_valid; if (demod_valid) exp_da = demod_data; end
      else if (ns == 3) begin exp_wr = demod_valid; exp_da = 8'd128; end
      else              begin exp_wr = 1'b0; exp_da = 8'd128; end
      m_state = ns;

      tick();
      exp_se = (m_state != 0) && (m_phase == DIV - 1);
      exp_fl = (m_state == 1);
      n_cmp++;
      if ({state, samp_en, demod_flush, da_wr, da_data, ovr_flag} !==
          {2'(m_state), exp_se, exp_fl, exp_wr, exp_da, m_ovr}) begin
        n_bad++;
        if (reported < 10) begin
          reported++;
          $display("FAIL random cyc %0d: got st=%0d se=%b fl=%b wr=%b da=%h ovr=%b, required %0d %b %b %b %h %b",
                   cyc, state, samp_en, demod_flush, da_wr, da_data, ovr_flag,
                   m_state, exp_se, exp_fl, exp_wr, exp_da, m_ovr);
        end
      end
    end
    start = 1'b0; demod_valid = 1'b0; ad_otr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_run_data();
    test_overrange();
    test_recovery();
    test_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fm_demod_sched.md
FM_DEMOD_SCHED -- requirements
Module: fm_demod_sched

Interface
REQ-001 Parameter DIV, default 5, sys_clk cycles per sample strobe (legal range 2..255).
REQ-002 Parameter WARM_N, default 64, samp_en pulses spent in WARMUP.
REQ-003 Parameter OTR_LIM, default 4, consecutive over-range samples that trigger MUTE.
REQ-004 Parameter REC_N, default 256, consecutive clean samples that trigger recovery to RUN.
REQ-005 sys_clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin acquisition.
REQ-008 stop  in  1  one-cycle request to end acquisition.
REQ-009 ad_otr  in  1  ADC over-range flag, sampled only when samp_en is high.
REQ-010 demod_data  in  8  demodulator output sample, unsigned, midscale 128.
REQ-011 demod_valid  in  1  qualifies demod_data.
REQ-012 samp_en  out  1  one-cycle ADC/demod sample strobe.
REQ-013 demod_flush  out  1  clears the demodulator pipeline.
REQ-014 da_data  out  8  DAC sample.
REQ-015 da_wr  out  1  DAC write strobe.
REQ-016 state  out  2  current FSM state encoding.
REQ-017 ovr_flag  out  1  sticky over-range indicator.

Function
REQ-018 FSM states: IDLE=0, WARMUP=1, RUN=2, MUTE=3.
REQ-019 Transitions: IDLE->WARMUP on start; WARMUP->RUN after WARM_N samp_en pulses; RUN->MUTE on OTR_LIM consecutive over-range samples; MUTE->RUN on REC_N consecutive clean samples; any state->IDLE on stop.
REQ-020 Divider counts 0..DIV-1 only outside IDLE, wraps to 0, and asserts samp_en for exactly one cycle when the count equals DIV-1.
REQ-021 On entering WARMUP, the divider is at 0, so the first samp_en occurs DIV cycles after start.
REQ-022 demod_flush is high in every WARMUP cycle and low in every other state.
REQ-023 In RUN, da_data is registered from demod_data and da_wr pulses one cycle after demod_valid (latency 1).
REQ-024 In WARMUP, da_wr stays low and da_data holds 128.
REQ-025 In MUTE, da_wr follows demod_valid with latency 1 and da_data is 128.
REQ-026 In IDLE, da_wr stays low and da_data holds 128.
REQ-027 In RUN, an over-range counter increments on samp_en with ad_otr=1 and clears on samp_en with ad_otr=0; it saturates at OTR_LIM.
REQ-028 In MUTE, a clean counter increments on samp_en with ad_otr=0 and clears on samp_en with ad_otr=1.
REQ-029 Both counters clear on every state change.
REQ-030 ovr_flag sets on the RUN->MUTE transition and clears only on an accepted start or on reset.
REQ-031 If start and stop are asserted in the same cycle, stop wins.
REQ-032 start outside IDLE is ignored.
REQ-033 On stop, da_data returns to 128 on the next cycle, and the divider and counters clear.

Reset
REQ-034 While sys_rst is high: state=IDLE, samp_en=0, demod_flush=0, da_data=128, da_wr=0, ovr_flag=0, and all counters are 0.
REQ-035 Reset asserted mid-operation overrides start and stop and takes effect on the next edge.

Structure
REQ-036 Package fm_pkg holds the state enum, the MIDSCALE=8'd128 constant and the default parameter constants.
REQ-037 The divider/strobe generator is a sub-module named fm_samp_strobe; the FSM, counters and DA register stay in the top module.

Verification
REQ-038 Scenario 1: reset, then start at cycle 10 -> first samp_en at cycle 15, demod_flush high for 320 cycles, then state=RUN.
REQ-039 Scenario 2: in RUN, demod_valid with demod_data=0xA5 -> da_data=0xA5 and da_wr=1 exactly one cycle later.
REQ-040 Scenario 3: ad_otr=1 on 3 strobes, then 0, then 1 on 4 strobes -> MUTE only after the 4th consecutive strobe, ovr_flag=1, da_data=128.
REQ-041 Scenario 4: in MUTE, 255 clean strobes, 1 over-range strobe, then 256 clean strobes -> RUN entered only after the final clean strobe; ovr_flag stays 1.
REQ-042 Scenario 5: start and stop in the same cycle from IDLE -> stays IDLE; stop during WARMUP -> IDLE next cycle with samp_en and demod_flush low.
REQ-043 Scenario 6: sys_rst pulsed in RUN -> all outputs at reset values next cycle; a subsequent start repeats the Scenario 1 timing.
